// File: rtl/chk_mon_pkg.sv
// Shared definitions for the checkpoint sequence monitor: FSM encoding,
// default failure code and index width for the stage counter.
package chk_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } mon_state_e;

  // Conventional "firmware died" checkpoint value
  localparam logic [15:0] DEF_FAIL_CODE = 16'hDEAD;

  // cur_stg / cfg_idx width (up to 16 stages)
  localparam int STG_IDX_W = 4;

endpackage

// File: rtl/chk_stable_filter.sv
// Two-flop synchronizer plus stability filter for the checkpoint bus.
// A value is accepted once it has been seen on the synchronized bus for
// STB_CYC consecutive samples and differs from the last accepted value;
// acc_o pulses for one cycle in the same cycle code_o takes the new value.
module chk_stable_filter #(
  parameter int CHK_W   = 16,
  parameter int STB_CYC = 3
) (
  input  logic             mclk,
  input  logic             reset_n,
  input  logic [CHK_W-1:0] chk_bits_i,
  output logic             acc_o,
  output logic [CHK_W-1:0] code_o
);

  localparam logic [3:0] STB = 4'(STB_CYC);

  logic [CHK_W-1:0] sync1_q, sync2_q;
  logic [CHK_W-1:0] cand_q, cand_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CHK_W-1:0] last_q, last_d;
  logic             acc_q, acc_d;

  // Run-length tracking of the synchronized value and accept decision
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = 4'd1;
    end else if (cnt_q != STB) begin
      cnt_d = cnt_q + 4'd1;
    end
    // cand_q has been seen STB_CYC times; only a value different from
    // the last accepted one produces a pulse, so a held code fires once
    acc_d  = (cnt_q == STB) && (cand_q != last_q);
    last_d = acc_d ? cand_q : last_q;
  end

  // Synchronizer, filter state and accepted-code registers
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      last_q  <= '0;
      acc_q   <= 1'b0;
    end else begin
      sync1_q <= chk_bits_i;
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      acc_q   <= acc_d;
    end
  end

  assign acc_o  = acc_q;
  assign code_o = last_q;

endmodule

// File: rtl/chk_seq_monitor.sv
// Checkpoint sequence monitor: watches an asynchronous checkpoint bus and
// checks that the programmed codes appear in order, each within a
// per-stage timeout. Reports pass, explicit failure or timeout failure.
module chk_seq_monitor
  import chk_mon_pkg::*;
#(
  parameter int CHK_W   = 16,
  parameter int NUM_STG = 4,
  parameter int TMO_W   = 24,
  parameter int STB_CYC = 3
) (
  input  logic                 mclk,
  input  logic                 reset_n,
  input  logic [CHK_W-1:0]     chk_bits,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 cfg_wr,
  input  logic [STG_IDX_W-1:0] cfg_idx,
  input  logic [CHK_W-1:0]     cfg_code,
  input  logic [CHK_W-1:0]     cfg_fail_code,
  input  logic [TMO_W-1:0]     cfg_tmo,
  output logic                 busy,
  output logic                 pass,
  output logic                 fail,
  output logic                 fail_tmo,
  output logic [STG_IDX_W-1:0] cur_stg,
  output logic [CHK_W-1:0]     last_code
);

  localparam logic [STG_IDX_W-1:0] LAST_STG = STG_IDX_W'(NUM_STG - 1);
  localparam logic [TMO_W-1:0]     TMR_ONE  = TMO_W'(1);

  logic                 acc;
  logic [CHK_W-1:0]     code;
  logic [CHK_W-1:0]     exp_q [NUM_STG];
  logic [CHK_W-1:0]     exp_cur;

  mon_state_e           state_q;
  logic [STG_IDX_W-1:0] stg_q;
  logic [TMO_W-1:0]     tmr_q;
  logic                 busy_q, pass_q, fail_q, ftmo_q;
  logic                 match, is_fail;

  chk_stable_filter #(
    .CHK_W   (CHK_W),
    .STB_CYC (STB_CYC)
  ) u_filt (
    .mclk       (mclk),
    .reset_n    (reset_n),
    .chk_bits_i (chk_bits),
    .acc_o      (acc),
    .code_o     (code)
  );

  // Expected-code table; out-of-range indices match no entry
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_STG; i++) exp_q[i] <= '0;
    end else if (cfg_wr) begin
      for (int i = 0; i < NUM_STG; i++)
        if (cfg_idx == STG_IDX_W'(i)) exp_q[i] <= cfg_code;
    end
  end

  // Expected code for the current stage, read live so table writes
  // made while busy apply at the next compare
  always_comb begin
    exp_cur = '0;
    for (int i = 0; i < NUM_STG; i++)
      if (stg_q == STG_IDX_W'(i)) exp_cur = exp_q[i];
  end

  assign match   = acc && (code == exp_cur);
  assign is_fail = acc && (code == cfg_fail_code);

  // Sequence FSM; abort beats start, a match beats both the failure code
  // and a simultaneous timer expiry
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      stg_q   <= '0;
      tmr_q   <= '0;
      busy_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      ftmo_q  <= 1'b0;
    end else if (abort) begin
      state_q <= ST_IDLE;
      stg_q   <= '0;
      tmr_q   <= '0;
      busy_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      ftmo_q  <= 1'b0;
    end else if (start) begin
      state_q <= ST_WAIT;
      stg_q   <= '0;
      tmr_q   <= cfg_tmo;
      busy_q  <= 1'b1;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      ftmo_q  <= 1'b0;
    end else if (state_q == ST_WAIT) begin
      if (match) begin
        if (stg_q == LAST_STG) begin
          state_q <= ST_PASS;
          busy_q  <= 1'b0;
          pass_q  <= 1'b1;
        end else begin
          stg_q <= stg_q + 1'b1;
          tmr_q <= cfg_tmo;
        end
      end else if (is_fail) begin
        state_q <= ST_FAIL;
        busy_q  <= 1'b0;
        fail_q  <= 1'b1;
        ftmo_q  <= 1'b0;
      end else if (cfg_tmo != '0) begin
        // Expiry is the 1 -> 0 step; a timer left at 0 by a previously
        // disabled timeout expires at once
        if (tmr_q <= TMR_ONE) begin
          tmr_q   <= '0;
          state_q <= ST_FAIL;
          busy_q  <= 1'b0;
          fail_q  <= 1'b1;
          ftmo_q  <= 1'b1;
        end else begin
          tmr_q <= tmr_q - TMR_ONE;
        end
      end
    end
  end

  assign busy      = busy_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign fail_tmo  = ftmo_q;
  assign cur_stg   = stg_q;
  assign last_code = code;

endmodule

// File: tb/tb_chk_seq_monitor.sv
// Self-checking bench for chk_seq_monitor (NUM_STG=2).
module tb_chk_seq_monitor;
  import chk_mon_pkg::*;

  localparam int CHK_W   = 16;
  localparam int NUM_STG = 2;
  localparam int TMO_W   = 24;
  localparam int STB_CYC = 3;

  logic             mclk = 1'b0;
  logic             reset_n;
  logic [CHK_W-1:0] chk_bits;
  logic             start, abort, cfg_wr;
  logic [3:0]       cfg_idx;
  logic [CHK_W-1:0] cfg_code, cfg_fail_code;
  logic [TMO_W-1:0] cfg_tmo;
  logic             busy, pass, fail, fail_tmo;
  logic [3:0]       cur_stg;
  logic [CHK_W-1:0] last_code;

  int checks   = 0;
  int failures = 0;
  logic [CHK_W-1:0] m_last;  // model of the last accepted code

  chk_seq_monitor #(
    .CHK_W(CHK_W), .NUM_STG(NUM_STG), .TMO_W(TMO_W), .STB_CYC(STB_CYC)
  ) dut (
    .mclk(mclk), .reset_n(reset_n), .chk_bits(chk_bits), .start(start),
    .abort(abort), .cfg_wr(cfg_wr), .cfg_idx(cfg_idx), .cfg_code(cfg_code),
    .cfg_fail_code(cfg_fail_code), .cfg_tmo(cfg_tmo), .busy(busy),
    .pass(pass), .fail(fail), .fail_tmo(fail_tmo), .cur_stg(cur_stg),
    .last_code(last_code)
  );

  always #5 mclk = ~mclk;

  task automatic tick(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  task automatic drive(input logic [CHK_W-1:0] v, input int n);
    chk_bits = v;
    tick(n);
  endtask

  task automatic cfg_write(input logic [3:0] idx, input logic [CHK_W-1:0] code);
    cfg_wr = 1'b1; cfg_idx = idx; cfg_code = code;
    tick(1);
    cfg_wr = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({busy, pass, fail, fail_tmo} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", {busy, pass, fail, fail_tmo});
    end
    checks++;
    if (cur_stg !== 4'd0 || last_code !== 16'h0000) begin
      failures++; $display("FAIL reset_stg_code got=%0h/%0h exp=0/0", cur_stg, last_code);
    end
    tick(3);
    reset_n = 1'b1;
    tick(10);
    checks++;
    if (busy !== 1'b0 || last_code !== 16'h0000) begin
      failures++; $display("FAIL post_reset_idle got busy=%b code=%0h exp 0/0", busy, last_code);
    end
  endtask

  task automatic test_pass();
    cfg_tmo = 24'd1000;
    cfg_write(4'd0, 16'hAB60);
    cfg_write(4'd1, 16'hAB6A);
    cfg_write(4'd2, 16'h1111);  // out of range, must not alias
    cfg_write(4'd3, 16'h2222);
    do_start();
    checks++;
    if (busy !== 1'b1 || cur_stg !== 4'd0 || pass !== 1'b0) begin
      failures++; $display("FAIL start_state got busy=%b stg=%0d pass=%b exp 1/0/0", busy, cur_stg, pass);
    end
    drive(16'hAB60, 10);
    checks++;
    if (cur_stg !== 4'd1 || busy !== 1'b1) begin
      failures++; $display("FAIL pass_stage1 got stg=%0d busy=%b exp 1/1", cur_stg, busy);
    end
    drive(16'hAB6A, 10);
    checks++;
    if ({pass, fail, busy} !== 3'b100 || cur_stg !== 4'd1 || last_code !== 16'hAB6A) begin
      failures++; $display("FAIL pass_done got p/f/b=%b stg=%0d code=%0h exp 100/1/ab6a",
                           {pass, fail, busy}, cur_stg, last_code);
    end
  endtask

  task automatic test_glitch_timeout();
    int n;
    drive(16'h0000, 10);
    do_start();
    drive(16'hAB60, 2);
    drive(16'hAB6A, 10);
    n = 12;
    checks++;
    if (last_code !== 16'hAB6A || busy !== 1'b1 || cur_stg !== 4'd0) begin
      failures++; $display("FAIL glitch_ignored got code=%0h busy=%b stg=%0d exp ab6a/1/0", last_code, busy, cur_stg);
    end
    while (fail !== 1'b1 && n < 2000) begin
      tick(1);
      n++;
    end
    checks++;
    if (n != 1000) begin
      failures++; $display("FAIL tmo_cycles got=%0d exp=1000", n);
    end
    checks++;
    if (fail_tmo !== 1'b1 || cur_stg !== 4'd0 || busy !== 1'b0 || pass !== 1'b0) begin
      failures++; $display("FAIL tmo_flags got ftmo=%b stg=%0d busy=%b pass=%b exp 1/0/0/0",
                           fail_tmo, cur_stg, busy, pass);
    end
  endtask

  task automatic test_fail_code();
    drive(16'h0000, 10);
    do_start();
    drive(16'hAB60, 10);
    drive(DEF_FAIL_CODE, 10);
    checks++;
    if ({fail, fail_tmo, busy} !== 3'b100 || cur_stg !== 4'd1 || last_code !== DEF_FAIL_CODE) begin
      failures++; $display("FAIL fail_code got f/ft/b=%b stg=%0d code=%0h exp 100/1/dead",
                           {fail, fail_tmo, busy}, cur_stg, last_code);
    end
  endtask

  // Timer/match coincidence, then reset while waiting at stage 1
  task automatic test_tmo_boundary();
    int lat;
    drive(16'h0000, 10);
    chk_bits = 16'hAB60;
    lat = 0;
    while (last_code !== 16'hAB60 && lat < 20) begin
      tick(1);
      lat++;
    end
    checks++;
    if (lat < STB_CYC + 2 || lat > STB_CYC + 5) begin
      failures++; $display("FAIL accept_latency got=%0d exp=%0d..%0d", lat, STB_CYC + 2, STB_CYC + 5);
    end
    // Timer hits zero one edge before the accept is seen: timeout wins
    drive(16'h0000, 10);
    cfg_tmo = TMO_W'(lat);
    do_start();
    drive(16'hAB60, lat);
    checks++;
    if (fail !== 1'b1 || fail_tmo !== 1'b1 || cur_stg !== 4'd0) begin
      failures++; $display("FAIL tmo_before_match got f/ft=%b%b stg=%0d exp 11/0", fail, fail_tmo, cur_stg);
    end
    // Accept lands on the edge where the timer is 1: match wins
    drive(16'h0000, 10);
    cfg_tmo = TMO_W'(lat + 1);
    do_start();
    drive(16'hAB60, lat + 1);
    checks++;
    if (cur_stg !== 4'd1 || fail !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL match_at_tmr1 got stg=%0d fail=%b busy=%b exp 1/0/1", cur_stg, fail, busy);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, pass, fail, fail_tmo, cur_stg, last_code} !== '0) begin
      failures++; $display("FAIL async_reset got b/p/f/ft=%b stg=%0d code=%0h exp all 0",
                           {busy, pass, fail, fail_tmo}, cur_stg, last_code);
    end
    tick(3);
    reset_n = 1'b1;
    tick(20);
    checks++;
    if ({busy, pass, fail} !== 3'b000 || cur_stg !== 4'd0 || last_code !== 16'hAB60) begin
      failures++; $display("FAIL idle_after_reset got b/p/f=%b stg=%0d code=%0h exp 000/0/ab60",
                           {busy, pass, fail}, cur_stg, last_code);
    end
    cfg_write(4'd0, 16'hAB60);
    cfg_write(4'd1, 16'hAB6A);
  endtask

  task automatic test_no_tmo_abort();
    int bad;
    cfg_tmo = '0;
    drive(16'h0000, 10);
    do_start();
    chk_bits = 16'hAB60;
    bad = 0;
    for (int i = 0; i < 50000; i++) begin
      tick(1);
      if (fail !== 1'b0 || busy !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0 || cur_stg !== 4'd1) begin
      failures++; $display("FAIL no_timeout got bad_cycles=%0d stg=%0d exp 0/1", bad, cur_stg);
    end
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    checks++;
    if ({busy, pass, fail} !== 3'b000) begin
      failures++; $display("FAIL abort_idle got b/p/f=%b exp 000", {busy, pass, fail});
    end
    start = 1'b1; abort = 1'b1;
    tick(1);
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL abort_over_start got busy=%b exp 0", busy);
    end
    drive(16'h0000, 10);
    do_start();
    drive(16'hAB60, 10);
    do_start();
    checks++;
    if (cur_stg !== 4'd0 || busy !== 1'b1) begin
      failures++; $display("FAIL restart_in_wait got stg=%0d busy=%b exp 0/1", cur_stg, busy);
    end
  endtask

  // Random code/hold sequences scored by a run-length model of the
  // stability rule and an in-order stage matcher
  task automatic test_random();
    logic [CHK_W-1:0] e [2];
    logic [CHK_W-1:0] sv [10];
    int               sh [10];
    int               ns, rl, stg;
    logic [CHK_W-1:0] rv;
    bit               wt, ps, fl;
    drive(16'h0000, 10);
    m_last = 16'h0000;
    for (int it = 0; it < 12; it++) begin
      e[0] = 16'($urandom);
      e[1] = 16'($urandom);
      cfg_write(4'd0, e[0]);
      cfg_write(4'd1, e[1]);
      ns = 4 + $urandom_range(0, 4);
      for (int k = 0; k < ns; k++) begin
        case ($urandom_range(0, 4))
          0: sv[k] = e[0];
          1: sv[k] = e[1];
          2: sv[k] = DEF_FAIL_CODE;
          3: sv[k] = 16'($urandom);
          default: sv[k] = (k > 0) ? sv[k-1] : e[0];
        endcase
        sh[k] = $urandom_range(1, 6);
      end
      sh[ns-1] += 12;
      rv = chk_bits;
      rl = 0;
      do_start();
      for (int k = 0; k < ns; k++) drive(sv[k], sh[k]);
      stg = 0; wt = 1'b1; ps = 1'b0; fl = 1'b0;
      for (int k = 0; k <= ns; k++) begin
        if (k < ns && sv[k] == rv) begin
          rl += sh[k];
        end else begin
          if (rl >= STB_CYC && rv != m_last) begin
            m_last = rv;
            if (wt) begin
              if (rv == e[stg]) begin
                if (stg == NUM_STG - 1) begin ps = 1'b1; wt = 1'b0; end
                else stg++;
              end else if (rv == DEF_FAIL_CODE) begin
                fl = 1'b1; wt = 1'b0;
              end
            end
          end
          if (k < ns) begin rv = sv[k]; rl = sh[k]; end
        end
      end
      checks++;
      if ({pass, fail, fail_tmo, busy} !== {ps, fl, 1'b0, wt}) begin
        failures++; $display("FAIL rand_flags it=%0d got p/f/ft/b=%b exp=%b", it,
                             {pass, fail, fail_tmo, busy}, {ps, fl, 1'b0, wt});
      end
      checks++;
      if (cur_stg !== 4'(stg) || last_code !== m_last) begin
        failures++; $display("FAIL rand_state it=%0d got stg=%0d code=%0h exp stg=%0d code=%0h",
                             it, cur_stg, last_code, stg, m_last);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; chk_bits = '0; start = 1'b0; abort = 1'b0;
    cfg_wr = 1'b0; cfg_idx = '0; cfg_code = '0;
    cfg_fail_code = DEF_FAIL_CODE; cfg_tmo = '0; m_last = '0;
    test_reset();
    test_pass();
    test_glitch_timeout();
    test_fail_code();
    test_tmo_boundary();
    test_no_tmo_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
